lock_sequencer: RTL and testbench
=================================

Name: lock_sequencer

Overview:
Single-clock sequencing controller for the push-button combination lock. It replaces the divided-clock lock FSM with a fully synchronous controller on the system clock, using an internal tick prescaler. It detects button presses, collects a fixed-length code, compares it with a stored code, and drives `unlock`, `alarm`, a failed-attempt count and a 3-bit state code for the 7-segment decoder. Code entry, unlock hold, lockout and re-programming are all sequenced here.

Parameters:
- CODE_LEN, 4, presses per code (1..8); b[0] press = bit 0, b[1] press = bit 1
- DEFAULT_CODE, 4'b1011, code loaded at reset (CODE_LEN bits, first press = MSB)
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..3)
- TICK_MAX, 49999999, prescaler terminal count; one tick = TICK_MAX+1 clk cycles
- ENTRY_TICKS, 5, inactivity ticks before a partial entry is abandoned
- UNLOCK_TICKS, 5, ticks `unlock` is held
- LOCKOUT_TICKS, 10, ticks of lockout

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- b  in  2  button levels, already synchronous to clk
- prog  in  1  program request level
- unlock  out  1  registered, high in UNLOCKED
- alarm  out  1  registered, high in LOCKOUT
- state  out  3  registered state code, zero-extended externally for the segment decoder
- tries  out  2  registered consecutive-failure count

Behaviour:
- Reset (rst=0, async): state=IDLE, code register=DEFAULT_CODE, entry register=0, press count=0, tries=0, unlock=0, alarm=0, prescaler and tick timer=0.
- State encoding is fixed: IDLE=0, ENTRY=1, CHECK=2, UNLOCKED=3, PROGRAM=4, LOCKOUT=5. 6 and 7 are illegal; recover to IDLE on the next clock.
- Press detect:
  - Register b every cycle. Press on bit i = b[i] & ~b_q[i].
  - Both bits rising in the same cycle is not a press and is ignored.
  - A press is accepted only in IDLE, ENTRY and PROGRAM.
- Entry register: shift left, new bit into the LSB. The press counter counts accepted presses.
- Prescaler and tick timer:
  - The prescaler counts 0..TICK_MAX and pulses tick for one cycle at TICK_MAX.
  - On every state entry and every accepted press, clear both the prescaler and the tick timer.
  - A timeout of N ticks therefore fires exactly N*(TICK_MAX+1) cycles after the last clear.
- IDLE:
  - A press loads the bit, sets count=1 and goes to ENTRY.
  - If CODE_LEN=1, go directly to CHECK instead.
- ENTRY:
  - Each press shifts in a bit. When count reaches CODE_LEN, go to CHECK on the next cycle.
  - ENTRY_TICKS elapsed with no press: go to IDLE, clear the entry register, leave tries unchanged.
- CHECK (exactly one cycle):
  - entry==code: go to UNLOCKED, tries=0.
  - Mismatch: tries+1. If tries+1==MAX_TRIES, go to LOCKOUT; otherwise go to IDLE.
  - Clear the entry register and count.
- UNLOCKED:
  - unlock=1 the cycle after CHECK, held UNLOCK_TICKS ticks, then IDLE.
  - prog=1 on any cycle: go to PROGRAM, count=0.
  - Presses are ignored.
- PROGRAM:
  - Collect CODE_LEN presses; on the last one load code<=entry and go to IDLE.
  - ENTRY_TICKS timeout: go to IDLE with the code unchanged.
  - unlock=0.
- LOCKOUT:
  - alarm=1, presses ignored.
  - After LOCKOUT_TICKS ticks: go to IDLE, tries=0, alarm=0.
- Outputs are registered and reflect the current state. `tries` saturates at MAX_TRIES.
- Reset asserted mid-operation returns to reset values immediately, including code=DEFAULT_CODE.

Optional Feature:
LOCK_PROG_EN
- Defined: PROGRAM state, `prog` input and writable code register operate as described.
- Undefined: `prog` is ignored, the code is the constant DEFAULT_CODE, and PROGRAM is unreachable (encoding 4 is treated as illegal). All other behaviour is identical.

Test Plan:
Bench parameters: CODE_LEN=4, DEFAULT_CODE=4'b1011, MAX_TRIES=3, TICK_MAX=3, ENTRY_TICKS=4, UNLOCK_TICKS=2, LOCKOUT_TICKS=3.
- Correct entry: presses b1,b0,b1,b1 → CHECK for 1 cycle → unlock=1 for exactly 8 cycles → state=0, tries=0.
- Three wrong entries of 0000 → tries 1, 2, then alarm=1 and state=5 for 12 cycles → IDLE with tries=0; presses during lockout have no effect.
- Partial entry b1,b0, then idle for 16 cycles → state returns to 0, tries unchanged. A later correct entry still unlocks.
- Both buttons rising in the same cycle, and holding a button high → no press or one press only. Releasing and re-pressing yields a new press.
- With LOCK_PROG_EN: unlock, prog=1, enter 0110 → code=0110. Entry 1011 now fails (tries=1); entry 0110 unlocks.
- Async reset asserted mid-ENTRY and mid-LOCKOUT → all outputs 0 immediately and the code restored to 1011.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer: single-clock push-button combination lock controller with an internal tick prescaler.
// Define LOCK_PROG_EN to enable code re-programming (PROGRAM state, prog input, writable code register).
module lock_sequencer #(
  parameter int unsigned          CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0]  DEFAULT_CODE  = 4'b1011,
  parameter int unsigned          MAX_TRIES     = 3,
  parameter int unsigned          TICK_MAX      = 49999999,
  parameter int unsigned          ENTRY_TICKS   = 5,
  parameter int unsigned          UNLOCK_TICKS  = 5,
  parameter int unsigned          LOCKOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] b,
  input  logic       prog,
  output logic       unlock,
  output logic       alarm,
  output logic [2:0] state,
  output logic [1:0] tries
);

  localparam int unsigned PW    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int unsigned TMAX0 = (ENTRY_TICKS > UNLOCK_TICKS) ? ENTRY_TICKS : UNLOCK_TICKS;
  localparam int unsigned TMAX  = (TMAX0 > LOCKOUT_TICKS) ? TMAX0 : LOCKOUT_TICKS;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam int unsigned CW    = $clog2(CODE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_PROGRAM  = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  // Timeout of n ticks: the tick that completes the n-th count since the last clear.
  function automatic logic f_timeout(input logic [TW-1:0] tmr, input logic tick, input int unsigned n);
    return tick && (tmr == TW'(n - 1));
  endfunction

  state_t              r_state, w_state_nx;
  logic [1:0]          r_b_q;
  logic [CODE_LEN-1:0] r_entry, w_entry_nx, w_shift, w_code;
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic [1:0]          r_tries, w_tries_nx, w_tries_inc;
  logic [PW-1:0]       r_presc;
  logic [TW-1:0]       r_tmr;
  logic                r_unlock, r_alarm;
  logic [1:0]          w_rise;
  logic                w_press, w_bit, w_tick, w_acc, w_clr;

`ifdef LOCK_PROG_EN
  logic [CODE_LEN-1:0] r_code, w_code_nx;
  assign w_code = r_code;
`else
  logic w_unused_prog;
  assign w_unused_prog = prog;
  assign w_code        = DEFAULT_CODE;
`endif

  // Simultaneous rising edges on both buttons are rejected as ambiguous.
  assign w_rise      = b & ~r_b_q;
  assign w_press     = w_rise[0] ^ w_rise[1];
  assign w_bit       = w_rise[1];
  assign w_tick      = (r_presc == PW'(TICK_MAX));
  assign w_shift     = (r_entry << 1) | CODE_LEN'(w_bit);
  assign w_tries_inc = (r_tries == 2'(MAX_TRIES)) ? r_tries : (r_tries + 2'd1);

  // Next-state, entry/count/tries/code update and timer-clear decode.
  always_comb begin
    w_state_nx = r_state;
    w_entry_nx = r_entry;
    w_cnt_nx   = r_cnt;
    w_tries_nx = r_tries;
    w_acc      = 1'b0;
`ifdef LOCK_PROG_EN
    w_code_nx  = r_code;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_acc      = 1'b1;
          w_entry_nx = CODE_LEN'(w_bit);
          w_cnt_nx   = CW'(1);
          w_state_nx = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
        end else begin
          w_entry_nx = '0;
          w_cnt_nx   = '0;
        end
      end
      S_ENTRY: begin
        if (w_press) begin
          w_acc      = 1'b1;
          w_entry_nx = w_shift;
          w_cnt_nx   = r_cnt + CW'(1);
          w_state_nx = (r_cnt == CW'(CODE_LEN - 1)) ? S_CHECK : S_ENTRY;
        end else if (f_timeout(r_tmr, w_tick, ENTRY_TICKS)) begin
          w_state_nx = S_IDLE;
          w_entry_nx = '0;
          w_cnt_nx   = '0;
        end else begin
          w_state_nx = S_ENTRY;
        end
      end
      S_CHECK: begin
        w_entry_nx = '0;
        w_cnt_nx   = '0;
        if (r_entry == w_code) begin
          w_state_nx = S_UNLOCKED;
          w_tries_nx = 2'd0;
        end else begin
          w_tries_nx = w_tries_inc;
          w_state_nx = (w_tries_inc == 2'(MAX_TRIES)) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_UNLOCKED: begin
`ifdef LOCK_PROG_EN
        if (prog) begin
          w_state_nx = S_PROGRAM;
          w_entry_nx = '0;
          w_cnt_nx   = '0;
        end else if (f_timeout(r_tmr, w_tick, UNLOCK_TICKS)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_UNLOCKED;
        end
`else
        if (f_timeout(r_tmr, w_tick, UNLOCK_TICKS)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_UNLOCKED;
        end
`endif
      end
`ifdef LOCK_PROG_EN
      S_PROGRAM: begin
        if (w_press) begin
          w_acc      = 1'b1;
          w_entry_nx = w_shift;
          w_cnt_nx   = r_cnt + CW'(1);
          if (r_cnt == CW'(CODE_LEN - 1)) begin
            w_code_nx  = w_shift;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_PROGRAM;
          end
        end else if (f_timeout(r_tmr, w_tick, ENTRY_TICKS)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_PROGRAM;
        end
      end
`endif
      S_LOCKOUT: begin
        if (f_timeout(r_tmr, w_tick, LOCKOUT_TICKS)) begin
          w_state_nx = S_IDLE;
          w_tries_nx = 2'd0;
        end else begin
          w_state_nx = S_LOCKOUT;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_entry_nx = '0;
        w_cnt_nx   = '0;
      end
    endcase
    w_clr = w_acc || (w_state_nx != r_state);
  end

  // State, datapath, prescaler/tick timer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_b_q    <= 2'b00;
      r_entry  <= '0;
      r_cnt    <= '0;
      r_tries  <= 2'd0;
      r_presc  <= '0;
      r_tmr    <= '0;
      r_unlock <= 1'b0;
      r_alarm  <= 1'b0;
`ifdef LOCK_PROG_EN
      r_code   <= DEFAULT_CODE;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_b_q    <= b;
      r_entry  <= w_entry_nx;
      r_cnt    <= w_cnt_nx;
      r_tries  <= w_tries_nx;
      r_unlock <= (w_state_nx == S_UNLOCKED);
      r_alarm  <= (w_state_nx == S_LOCKOUT);
`ifdef LOCK_PROG_EN
      r_code   <= w_code_nx;
`endif
      if (w_clr) begin
        r_presc <= '0;
        r_tmr   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_tmr   <= (r_tmr == {TW{1'b1}}) ? r_tmr : (r_tmr + TW'(1));
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign unlock = r_unlock;
  assign alarm  = r_alarm;
  assign state  = r_state;
  assign tries  = r_tries;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: cycle-count reference model plus directed and random stimulus.
module tb_lock_sequencer;
  localparam int CL  = 4;
  localparam int TM  = 3;
  localparam int ET  = 4;
  localparam int UT  = 2;
  localparam int LT  = 3;
  localparam int MT  = 3;
  localparam int CYC = TM + 1;
  localparam logic [3:0] DEF = 4'b1011;
`ifdef LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       clk, rst, prog, unlock, alarm;
  logic [1:0] b, tries;
  logic [2:0] state;
  int n_vec = 0;
  int n_err = 0;

  lock_sequencer #(
    .CODE_LEN(CL), .DEFAULT_CODE(DEF), .MAX_TRIES(MT), .TICK_MAX(TM),
    .ENTRY_TICKS(ET), .UNLOCK_TICKS(UT), .LOCKOUT_TICKS(LT)
  ) dut (
    .clk(clk), .rst(rst), .b(b), .prog(prog),
    .unlock(unlock), .alarm(alarm), .state(state), .tries(tries)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode numbers are the published state codes; timeouts are counted in raw cycles.
  int m_mode, m_code, m_entry, m_cnt, m_tries, m_el;
  logic [1:0] m_bq;

  always @(posedge clk or negedge rst) begin : p_model
    logic [1:0] rise;
    bit pr, acc;
    int pb, nx;
    if (!rst) begin
      m_mode = 0; m_code = int'(DEF); m_entry = 0; m_cnt = 0; m_tries = 0; m_el = 0; m_bq = 2'b00;
    end else begin
      rise = b & ~m_bq;
      m_bq = b;
      pr   = (rise == 2'b01) || (rise == 2'b10);
      pb   = rise[1] ? 1 : 0;
      acc  = pr && (m_mode == 0 || m_mode == 1 || m_mode == 4);
      nx   = m_mode;
      if (acc) begin
        m_entry = (m_entry * 2 + pb) % (1 << CL);
        m_cnt++;
        if (m_cnt == CL) begin
          if (m_mode == 4) begin m_code = m_entry; nx = 0; end
          else nx = 2;
        end else nx = (m_mode == 4) ? 4 : 1;
      end else begin
        case (m_mode)
          1: if (m_el + 1 == ET * CYC) nx = 0;
          2: begin
            if (m_entry == m_code) begin nx = 3; m_tries = 0; end
            else begin
              m_tries = (m_tries < MT) ? m_tries + 1 : MT;
              nx = (m_tries == MT) ? 5 : 0;
            end
          end
          3: begin
            if (PROG_EN && prog) nx = 4;
            else if (m_el + 1 == UT * CYC) nx = 0;
          end
          4: if (m_el + 1 == ET * CYC) nx = 0;
          5: if (m_el + 1 == LT * CYC) begin nx = 0; m_tries = 0; end
          default: nx = 0;
        endcase
      end
      if (nx == 0 || m_mode == 2 || (nx == 4 && m_mode == 3)) begin m_entry = 0; m_cnt = 0; end
      if (acc || nx != m_mode) m_el = 0;
      else m_el++;
      m_mode = nx;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n_vec++;
      if (state !== 3'(m_mode) || unlock !== (m_mode == 3) || alarm !== (m_mode == 5) || tries !== 2'(m_tries)) begin
        n_err++;
        $display("FAIL model t=%0t: got state=%0d unlock=%b alarm=%b tries=%0d, expected state=%0d unlock=%b alarm=%b tries=%0d",
                 $time, state, unlock, alarm, tries, m_mode, (m_mode == 3), (m_mode == 5), m_tries);
      end
    end
  end

  // Length in cycles of the most recently completed residence in each state code.
  int run_len[8];
  int cur_st, cur_len;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      cur_st = 0; cur_len = 0;
    end else if (int'(state) == cur_st) begin
      cur_len++;
    end else begin
      run_len[cur_st] = cur_len;
      cur_st = int'(state);
      cur_len = 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input int hold);
    b = v;
    repeat (hold) @(negedge clk);
    b = 2'b00;
    @(negedge clk);
  endtask

  task automatic press(input int bt);
    drive((bt != 0) ? 2'b10 : 2'b01, 1);
  endtask

  task automatic enter(input int c);
    for (int i = CL - 1; i >= 0; i--) press((c >> i) & 1);
  endtask

  task automatic wait_state(input int st, input int budget);
    int k = 0;
    while (int'(state) != st && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_state", int'(state), st);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_state"}, int'(state), 0);
    chk({nm, "_unlock"}, int'(unlock), 0);
    chk({nm, "_alarm"}, int'(alarm), 0);
    chk({nm, "_tries"}, int'(tries), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; b = 2'b00; prog = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Correct code: one CHECK cycle, then 2 ticks * 4 cycles of unlock.
    enter(int'(DEF));
    chk("unlock_after_entry", int'(unlock), 1);
    wait_state(0, 40);
    chk("check_len", run_len[2], 1);
    chk("unlock_len", run_len[3], 8);
    chk("tries_after_unlock", int'(tries), 0);

    // Three wrong codes lead to 12 cycles of lockout; presses inside it do nothing.
    enter(0);
    chk("tries_1", int'(tries), 1);
    enter(0);
    chk("tries_2", int'(tries), 2);
    enter(0);
    chk("lockout_state", int'(state), 5);
    chk("lockout_alarm", int'(alarm), 1);
    press(1); press(0); press(1);
    wait_state(0, 40);
    chk("lockout_len", run_len[5], 12);
    chk("tries_after_lockout", int'(tries), 0);
    idle(3);
    chk("idle_after_lockout", int'(state), 0);

    // Abandoned partial entry: 2 press cycles + 16 idle cycles in ENTRY, tries kept.
    enter(0);
    press(1); press(0);
    wait_state(0, 40);
    chk("entry_timeout_len", run_len[1], 18);
    chk("tries_kept", int'(tries), 1);
    enter(int'(DEF));
    wait_state(0, 40);
    chk("unlock_after_timeout", run_len[3], 8);
    chk("tries_cleared", int'(tries), 0);

    // Both buttons together are ignored; a held button counts once.
    drive(2'b11, 1);
    idle(2);
    chk("both_ignored", int'(state), 0);
    drive(2'b10, 6);
    chk("hold_one_press", int'(state), 1);
    press(0); press(1); press(1);
    wait_state(0, 40);
    chk("hold_then_unlock", run_len[3], 8);

`ifdef LOCK_PROG_EN
    enter(int'(DEF));
    chk("prog_unlocked", int'(unlock), 1);
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    chk("prog_state", int'(state), 4);
    chk("prog_unlock_low", int'(unlock), 0);
    enter(6);
    chk("prog_done_idle", int'(state), 0);
    enter(int'(DEF));
    chk("old_code_fails", int'(tries), 1);
    enter(6);
    chk("new_code_unlocks", int'(unlock), 1);
    wait_state(0, 40);
`else
    enter(int'(DEF));
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    chk("prog_ignored", int'(state), 3);
    wait_state(0, 40);
    chk("prog_ignored_len", run_len[3], 8);
`endif

    for (int it = 0; it < 300; it++) begin
      int op;
      op   = $urandom_range(0, 9);
      prog = ($urandom_range(0, 7) == 0);
      if (op < 5) drive(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, $urandom_range(1, 3));
      else if (op < 7) idle($urandom_range(1, 20));
      else if (op == 7) drive(2'($urandom_range(0, 3)), $urandom_range(1, 2));
      else enter(m_code);
    end
    prog = 1'b0;

    // Asynchronous reset in the middle of an entry.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(1);
    chk("pre_reset_entry", int'(state), 1);
    #2 rst = 1'b0;
    #1;
    chk_zero("reset_mid_entry");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    enter(int'(DEF));
    chk("default_code_restored", int'(unlock), 1);
    wait_state(0, 40);
    chk("restored_unlock_len", run_len[3], 8);

    // Asynchronous reset in the middle of lockout.
    enter(0); enter(0); enter(0);
    chk("pre_reset_lockout", int'(state), 5);
    #2 rst = 1'b0;
    #1;
    chk_zero("reset_mid_lockout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    enter(6);
    chk("code_0110_rejected", int'(tries), 1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
